// File: rtl/neuron_accumulator_pkg.sv
// ---------------------------------------------------------------------------
// neural_pkg
//   Definitions shared by the neuron datapath stages:
//     DEF_DATA_W / DEF_FRAC_BITS  default data format (Q4.4, 8-bit signed)
//     GRP_*                       bias group codes driven to the bias mux
//     state_t                     neuron accumulator FSM states
//     acc_width()                 accumulator width that cannot overflow
// ---------------------------------------------------------------------------
package neural_pkg;

    localparam int DEF_DATA_W    = 8;
    localparam int DEF_FRAC_BITS = 4;

    // Bias group codes seen by the bias mux.
    localparam logic [1:0] GRP_HID0  = 2'b00;
    localparam logic [1:0] GRP_HID10 = 2'b01;
    localparam logic [1:0] GRP_HID20 = 2'b10;
    localparam logic [1:0] GRP_OUT   = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD_BIAS = 3'd1,
        ST_ACCUM     = 3'd2,
        ST_FINISH    = 3'd3,
        ST_OUT       = 3'd4
    } state_t;

    // Full-precision product is 2*data_w bits; summing n_in of them plus a
    // bias seed needs log2(n_in+1) growth bits, and one extra bit of margin.
    function automatic int acc_width(input int data_w, input int n_in);
        return 2 * data_w + $clog2(n_in + 1) + 1;
    endfunction

endpackage

// File: rtl/neuron_accumulator_if.sv
// ---------------------------------------------------------------------------
// neuron_accumulator_if
//   Operand beat stream into the neuron and result stream out of it.
//     in_valid / in_ready   beat handshake (producer -> neuron)
//     act_i / wgt_i         signed activation and weight of one beat
//     out_valid / out_ready result handshake (neuron -> consumer)
//     out_data              signed saturated result
//   master : the side that feeds operands and consumes results
//   slave  : the neuron accumulator itself
// ---------------------------------------------------------------------------
interface neuron_accumulator_if #(
    parameter int DATA_W = neural_pkg::DEF_DATA_W
);

    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] act_i;
    logic signed [DATA_W-1:0] wgt_i;

    logic                     out_valid;
    logic                     out_ready;
    logic signed [DATA_W-1:0] out_data;

    modport master (
        output in_valid, act_i, wgt_i, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, act_i, wgt_i, out_ready,
        output in_ready, out_valid, out_data
    );

endinterface

// File: rtl/neuron_post.sv
// ---------------------------------------------------------------------------
// neuron_post
//   Combinational post-processing of a wide accumulator value:
//   shift back to the data format (arithmetic, floor), optional ReLU,
//   saturate to the signed DATA_W range.
//   Ports:
//     acc      in   ACC_W   signed accumulator (DATA_W.2*FRAC_BITS scaling)
//     relu_en  in   1       1 = clamp negative values to 0
//     result   out  DATA_W  signed saturated result
// ---------------------------------------------------------------------------
module neuron_post
    import neural_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int FRAC_BITS = DEF_FRAC_BITS,
    parameter int ACC_W     = 2 * DEF_DATA_W + 2
) (
    input  logic signed [ACC_W-1:0]  acc,
    input  logic                     relu_en,
    output logic signed [DATA_W-1:0] result
);

    function automatic logic signed [ACC_W-1:0] apply_relu(
        input logic signed [ACC_W-1:0] v,
        input logic                    en
    );
        if (en && (v < 0)) begin
            return '0;
        end
        return v;
    endfunction

    function automatic logic signed [DATA_W-1:0] saturate(
        input logic signed [ACC_W-1:0] v
    );
        logic signed [ACC_W-1:0] hi;
        logic signed [ACC_W-1:0] lo;
        // hi = 2^(DATA_W-1)-1, lo = -2^(DATA_W-1), both at full width
        hi = '0;
        hi[DATA_W-2:0] = '1;
        lo = '1;
        lo[DATA_W-2:0] = '0;
        if (v > hi) begin
            return hi[DATA_W-1:0];
        end
        if (v < lo) begin
            return lo[DATA_W-1:0];
        end
        return v[DATA_W-1:0];
    endfunction

    logic signed [ACC_W-1:0] shifted;
    logic signed [ACC_W-1:0] rectified;

    // Arithmetic shift rounds toward minus infinity.
    assign shifted   = acc >>> FRAC_BITS;
    assign rectified = apply_relu(shifted, relu_en);
    assign result    = saturate(rectified);

endmodule

// File: rtl/neuron_accumulator.sv
// ---------------------------------------------------------------------------
// neuron_accumulator
//   Per-neuron multiply-accumulate stage. Selects a bias through an external
//   mux, seeds the accumulator with it, sums N_IN activation*weight products,
//   then shifts, optionally rectifies and saturates the sum to DATA_W bits.
//   Ports:
//     clk         in   1       rising-edge clock
//     rst_n       in   1       asynchronous active-low reset
//     start       in   1       begin a neuron (honoured only when idle)
//     group_i     in   2       bias group code, captured on start
//     relu_en     in   1       ReLU enable, captured on start
//     bias_sel_o  out  2       registered select to the bias mux
//     bias_i      in   DATA_W  bias returned by the mux
//     bus         slave       operand beats in, result out (valid/ready)
//     busy        out  1       high whenever not idle
// ---------------------------------------------------------------------------
module neuron_accumulator
    import neural_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int N_IN      = 30,
    parameter int FRAC_BITS = DEF_FRAC_BITS
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [1:0]               group_i,
    input  logic                     relu_en,
    output logic [1:0]               bias_sel_o,
    input  logic signed [DATA_W-1:0] bias_i,
    neuron_accumulator_if.slave      bus,
    output logic                     busy
);

    localparam int ACC_W = acc_width(DATA_W, N_IN);
    localparam int CNT_W = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(N_IN - 1);

    state_t state;
    state_t state_next;

    logic signed [ACC_W-1:0]    acc;
    logic [CNT_W-1:0]           count;
    logic                       relu_q;
    logic                       out_valid_q;
    logic signed [DATA_W-1:0]   out_data_q;
    logic signed [DATA_W-1:0]   post_result;
    logic signed [2*DATA_W-1:0] product;
    logic                       beat;

    // Full-precision signed product; no truncation before accumulation.
    assign product = bus.act_i * bus.wgt_i;
    assign beat    = bus.in_valid && (state == ST_ACCUM);

    assign bus.in_ready  = (state == ST_ACCUM);
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign busy          = (state != ST_IDLE);

    // -------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------
    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_LOAD_BIAS;
                end
            end
            ST_LOAD_BIAS: begin
                state_next = ST_ACCUM;
            end
            ST_ACCUM: begin
                if (beat && (count == LAST_BEAT)) begin
                    state_next = ST_FINISH;
                end
            end
            ST_FINISH: begin
                state_next = ST_OUT;
            end
            ST_OUT: begin
                if (bus.out_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -------------------------------------------------------------------
    // Datapath registers
    // -------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc         <= '0;
            count       <= '0;
            relu_q      <= 1'b0;
            bias_sel_o  <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        bias_sel_o <= group_i;
                        relu_q     <= relu_en;
                    end
                end
                ST_LOAD_BIAS: begin
                    // Bias is in data format; move it to product scaling.
                    acc   <= ACC_W'(bias_i) <<< FRAC_BITS;
                    count <= '0;
                end
                ST_ACCUM: begin
                    if (beat) begin
                        acc   <= acc + ACC_W'(product);
                        count <= count + 1'b1;
                    end
                end
                ST_FINISH: begin
                    out_data_q  <= post_result;
                    out_valid_q <= 1'b1;
                end
                ST_OUT: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    neuron_post #(
        .DATA_W    (DATA_W),
        .FRAC_BITS (FRAC_BITS),
        .ACC_W     (ACC_W)
    ) u_post (
        .acc     (acc),
        .relu_en (relu_q),
        .result  (post_result)
    );

endmodule
